// File: rtl/uart_tx_arbiter_if.sv
// Bundle between N_REQ byte requesters, the shared UART transmitter and the arbiter.
// The master modport is the arbiter's view; slave is the requesters/transmitter side.
interface uart_tx_arbiter_if #(
   parameter int unsigned N_REQ = 4
);
   logic [N_REQ-1:0]   req_valid;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   req_lock;
   logic [N_REQ-1:0]   req_ready;
   logic [N_REQ-1:0]   grant;
   logic               tx_start;
   logic [7:0]         tx_data;
   logic               tx_busy;
   logic               tx_err;

   modport master (
      input  req_valid, req_data, req_lock, tx_busy,
      output req_ready, grant, tx_start, tx_data, tx_err
   );

   modport slave (
      output req_valid, req_data, req_lock, tx_busy,
      input  req_ready, grant, tx_start, tx_data, tx_err
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte requesters, with
// optional locked bursts of up to MAX_BURST bytes and a start-handshake timeout.
module uart_tx_arbiter #(
   parameter int unsigned N_REQ         = 4,
   parameter int unsigned MAX_BURST     = 4,
   parameter int unsigned START_TIMEOUT = 4
) (
   input logic               clk,
   input logic               rst,
   uart_tx_arbiter_if.master bus
);
   localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {StIdle, StWaitBusy, StWaitDone} state_e;

   state_e           state_q, state_d;
   logic [IdxW-1:0]  owner_q, owner_d, last_q, last_d, win;
   logic             win_vld;
   logic [3:0]       burst_q, burst_d, tmo_q, tmo_d;
   logic [N_REQ-1:0] grant_q, grant_d, ready_q, ready_d;
   logic             start_q, start_d, err_q, err_d;
   logic [7:0]       data_q, data_d;
   logic             sel, timeout, reissue, done;
   int unsigned      cand;

   // Round-robin pick: first valid requester strictly after the last owner, wrapping.
   always_comb begin
      win     = last_q;
      win_vld = 1'b0;
      cand    = 0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         cand = (32'(last_q) + k) % N_REQ;
         if (!win_vld && bus.req_valid[cand]) begin
            win     = IdxW'(cand);
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      sel     = (state_q == StIdle) && !bus.tx_busy && win_vld;
      timeout = (state_q == StWaitBusy) && !bus.tx_busy && (tmo_q == 4'(START_TIMEOUT - 1));
      reissue = (state_q == StWaitDone) && !bus.tx_busy && bus.req_lock[owner_q] &&
                bus.req_valid[owner_q] && (burst_q < 4'(MAX_BURST - 1));
      done    = (state_q == StWaitDone) && !bus.tx_busy && !reissue;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         owner_q <= '0;
         last_q  <= IdxW'(N_REQ - 1);
         burst_q <= '0;
         tmo_q   <= '0;
         grant_q <= '0;
         ready_q <= '0;
         start_q <= 1'b0;
         err_q   <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         burst_q <= burst_d;
         tmo_q   <= tmo_d;
         grant_q <= grant_d;
         ready_q <= ready_d;
         start_q <= start_d;
         err_q   <= err_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:     if (sel) state_d = StWaitBusy;
         StWaitBusy: begin
            if (bus.tx_busy) state_d = StWaitDone;
            else if (timeout) state_d = StIdle;
         end
         StWaitDone: begin
            if (reissue) state_d = StWaitBusy;
            else if (done) state_d = StIdle;
         end
         default:    state_d = StIdle;
      endcase
   end

   always_comb begin
      owner_d = owner_q;
      last_d  = last_q;
      burst_d = burst_q;
      tmo_d   = tmo_q;
      grant_d = grant_q;
      data_d  = data_q;
      ready_d = '0;
      start_d = 1'b0;
      err_d   = 1'b0;
      if (sel) begin
         owner_d = win;
         data_d  = bus.req_data[8*32'(win) +: 8];
         start_d = 1'b1;
         ready_d = {{(N_REQ-1){1'b0}}, 1'b1} << win;
         grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << win;
         burst_d = '0;
         tmo_d   = '0;
      end
      if (state_q == StWaitBusy && !bus.tx_busy && !timeout) tmo_d = tmo_q + 4'd1;
      if (timeout) begin
         err_d   = 1'b1;
         grant_d = '0;
         last_d  = owner_q;
      end
      if (reissue) begin
         data_d  = bus.req_data[8*32'(owner_q) +: 8];
         start_d = 1'b1;
         ready_d = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
         burst_d = burst_q + 4'd1;
         tmo_d   = '0;
      end
      if (done) begin
         grant_d = '0;
         last_d  = owner_q;
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.grant     = grant_q;
   assign bus.tx_start  = start_q;
   assign bus.tx_data   = data_q;
   assign bus.tx_err    = err_q;
endmodule
